// File: rtl/rr_mux_arbiter_if.sv
// ============================================================================
// Module  : rr_mux_arbiter_if
// Purpose : Requester/downstream bundle for the 8-way round-robin arbiter.
// Rev     : 1.0
// ============================================================================
`default_nettype none

interface rr_mux_arbiter_if #(
    parameter int DATA_W = 4
);
    logic [DATA_W-1:0] S0, S1, S2, S3, S4, S5, S6, S7;
    logic [7:0]        REQ;
    logic              READY;
    logic [DATA_W-1:0] SAIDA;
    logic [2:0]        ID;
    logic              VALID;
    logic [7:0]        ACK;

    // Arbiter side.
    modport slave (
        input  S0, S1, S2, S3, S4, S5, S6, S7, REQ, READY,
        output SAIDA, ID, VALID, ACK
    );

    // Requesters plus downstream consumer side.
    modport master (
        output S0, S1, S2, S3, S4, S5, S6, S7, REQ, READY,
        input  SAIDA, ID, VALID, ACK
    );
endinterface

`default_nettype wire

// File: rtl/rr_mux_arbiter.sv
// ============================================================================
// Module  : rr_mux_arbiter
// Purpose : Round-robin 8:1 selector with registered word/index and handshake.
// Rev     : 1.0
// ============================================================================
`default_nettype none

module rr_mux_arbiter #(
    parameter int DATA_W = 4
) (
    input  wire logic          clk,
    input  wire logic          rst_n,
    rr_mux_arbiter_if.slave    bus
);
    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

    state_t            state_q;
    logic [2:0]        ptr_q;
    logic [2:0]        id_q;
    logic [DATA_W-1:0] saida_q;
    logic              valid_q;

    logic [DATA_W-1:0] w_s [8];
    logic [2:0]        w_win;
    logic              w_found;
    logic [2:0]        ptr_d;

    assign w_s[0] = bus.S0;
    assign w_s[1] = bus.S1;
    assign w_s[2] = bus.S2;
    assign w_s[3] = bus.S3;
    assign w_s[4] = bus.S4;
    assign w_s[5] = bus.S5;
    assign w_s[6] = bus.S6;
    assign w_s[7] = bus.S7;

    // First requester at or after the pointer, wrapping through 7 -> 0.
    always_comb begin
        w_found = 1'b0;
        w_win   = 3'd0;
        for (int k = 0; k < 8; k++) begin
            if (!w_found && bus.REQ[ptr_q + 3'(k)]) begin
                w_found = 1'b1;
                w_win   = ptr_q + 3'(k);
            end
        end
    end

    // Pointer moves just past the served index; 3-bit arithmetic wraps 7 to 0.
    assign ptr_d = id_q + 3'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            ptr_q   <= 3'd0;
            id_q    <= 3'd0;
            saida_q <= '0;
            valid_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (w_found) begin
                        saida_q <= w_s[w_win];
                        id_q    <= w_win;
                        valid_q <= 1'b1;
                        state_q <= SEND;
                    end
                end
                SEND: begin
                    if (bus.READY) begin
                        ptr_q   <= ptr_d;
                        valid_q <= 1'b0;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    valid_q <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.SAIDA = saida_q;
    assign bus.ID    = id_q;
    assign bus.VALID = valid_q;
    assign bus.ACK   = (valid_q && bus.READY) ? (8'b1 << id_q) : 8'b0;

endmodule

`default_nettype wire

// File: doc/rr_mux_arbiter.md
Name: rr_mux_arbiter

Overview:
- Round-robin arbiter that shares one 8:1, DATA_W-bit selection path between 8 requesters.
- Picks one requester, registers its data word and 3-bit source index, and presents them downstream with a valid/ready handshake.
- Returns a one-cycle one-hot acknowledge to the winning requester when the word is consumed.
- Sits in front of the 8-way selector datapath and generates its SEL/ID sequencing.

Parameters:
- DATA_W, 4, width of each requester data word and of SAIDA.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- S0..S7  input  DATA_W each  requester data words; Sk belongs to requester k.
- REQ  input  8  REQ[k]=1: requester k has a word pending; level, held until ACK[k].
- READY  input  1  downstream accepts the word this cycle.
- SAIDA  output  DATA_W  registered data of the current grant.
- ID  output  3  registered index of the current grant.
- VALID  output  1  SAIDA/ID hold a word awaiting acceptance.
- ACK  output  8  one-hot; ACK[ID]=1 in the handshake cycle only.

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values, applied immediately on rst_n low:
  - state=IDLE, PTR=0, SAIDA=0, ID=0, VALID=0, ACK=0.
- State IDLE:
  - VALID=0.
  - At a rising edge with REQ!=0, the winner is the first index i scanning PTR, PTR+1, … , 7, 0, … , PTR-1 (mod 8) with REQ[i]=1.
  - On that edge: SAIDA<=Si, ID<=i, state<=SEND.
  - With REQ==0: stay in IDLE, all outputs hold.
- State SEND:
  - VALID=1. SAIDA and ID are held stable.
  - Changes on S*/REQ after capture do not affect SAIDA or ID.
  - While READY=0: stay in SEND, no ACK, no time-out.
- Handshake cycle (SEND and READY=1):
  - ACK is combinational: ACK = VALID&&READY ? (8'b1<<ID) : 0.
  - At the edge: PTR<=(ID+1) mod 8 (3-bit wrap; ID=7 gives PTR=0), state<=IDLE.
  - SAIDA/ID keep their last value until the next grant.
- Throughput and latency:
  - One word per 2 cycles maximum; there is one IDLE bubble after every handshake.
  - Latency from REQ seen at an IDLE edge to VALID=1 is 1 cycle.
- The requester must drop REQ[k] the cycle after ACK[k] if it has no further word.
  - If it keeps REQ[k] high, that is a new request, served only after every other active requester, because PTR has moved past k.
- REQ withdrawn while its grant is in SEND: the transfer still completes with the captured data, and ACK still pulses.
- READY while VALID=0: ignored, ACK=0.
- Simultaneous requests: served strictly in round-robin order from PTR. No requester waits more than 7 grants.
- Reset mid-transfer: the pending word is discarded with no ACK. After reset, PTR=0.
- Exactly one arbitration decision per IDLE cycle. ACK never has more than one bit set.

Test Plan:
- Reset, then REQ=8'h00 for 5 cycles -> VALID=0, ACK=0, SAIDA=0, ID=0 throughout.
- REQ=8'h04, S2=4'hA, READY=1 -> VALID=1 one cycle after the edge, ID=2, SAIDA=A, ACK=8'h04 for one cycle, then VALID=0; PTR=3.
- After reset, REQ=8'hFF held, READY=1, S k = k -> (ID,SAIDA) sequence 0,1,…,7,0 on every other cycle; each ACK one-hot matches ID.
- PTR=3, REQ=8'h81 -> grant ID=7 first, then ID=0 (wrap), then PTR=1.
- Grant ID=5 with S5=4'h6, hold READY=0 for 4 cycles while S5 changes to 4'hF and REQ[5] drops -> SAIDA stays 6, VALID stays 1, ACK=0 until READY=1, then ACK=8'h20.
- In SEND with ID=4, assert rst_n=0 asynchronously mid-cycle -> VALID, ACK and SAIDA go to 0 immediately; after release with REQ=8'h30, first grant is ID=4 (PTR=0).
